// File: rtl/score_table_ctrl.sv
// Best-score bookkeeping for the word-scramble game: arbitrates the per-player
// score RAM between result posting and best-score lookup, and keeps a top-3 leaderboard.
module score_table_ctrl #(
  parameter int SCORE_W = 7,
  parameter int PID_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_req,
  output logic               clr_ack,
  input  logic               upd_req,
  input  logic [PID_W-1:0]   upd_pid,
  input  logic               upd_guest,
  input  logic [SCORE_W-1:0] upd_score,
  output logic               upd_ack,
  output logic               upd_new_best,
  input  logic               rd_req,
  input  logic [PID_W-1:0]   rd_pid,
  output logic               rd_ack,
  output logic [SCORE_W-1:0] rd_score,
  output logic [PID_W-1:0]   top_pid0,
  output logic [PID_W-1:0]   top_pid1,
  output logic [PID_W-1:0]   top_pid2,
  output logic [SCORE_W-1:0] top_score0,
  output logic [SCORE_W-1:0] top_score1,
  output logic [SCORE_W-1:0] top_score2,
  output logic [2:0]         top_valid,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [PID_W-1:0]   mem_addr,
  output logic [SCORE_W-1:0] mem_wdata,
  input  logic [SCORE_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    UPD_RD  = 3'd2,
    UPD_CMP = 3'd3,
    UPD_WR  = 3'd4,
    TOP_INS = 3'd5,
    RD_RD   = 3'd6,
    RD_CAP  = 3'd7
  } stateT;

  localparam logic [PID_W-1:0] LAST_ADDR = {PID_W{1'b1}};
  localparam logic [PID_W-1:0] ADDR_ONE  = {{(PID_W-1){1'b0}}, 1'b1};

  stateT              state;
  logic [PID_W-1:0]   pidR;
  logic [SCORE_W-1:0] scoreR;
  logic [PID_W-1:0]   clrCnt;
  logic               memEnR;
  logic               memWeR;
  logic [PID_W-1:0]   lbPid   [3];
  logic [SCORE_W-1:0] lbScore [3];
  logic [2:0]         lbValid;
  logic [PID_W-1:0]   nPid    [3];
  logic [SCORE_W-1:0] nScore  [3];
  logic [2:0]         nValid;
  logic [1:0]         n;
  logic               placed;
  logic               ackAny;

  assign ackAny     = clr_ack | upd_ack | rd_ack;
  // Gating with rst keeps the RAM write strobe low during the reset cycle itself.
  assign mem_en     = memEnR & rst;
  assign mem_we     = memWeR & rst;
  assign top_pid0   = lbPid[0];
  assign top_pid1   = lbPid[1];
  assign top_pid2   = lbPid[2];
  assign top_score0 = lbScore[0];
  assign top_score1 = lbScore[1];
  assign top_score2 = lbScore[2];
  assign top_valid  = lbValid;

  // Next leaderboard: drop same-pid entry, slot candidate after every entry scoring >= it.
  always_comb begin
    nPid   = '{default: '0};
    nScore = '{default: '0};
    nValid = 3'b000;
    n      = 2'd0;
    placed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (lbValid[i] && (lbPid[i] != pidR)) begin
        if (!placed && (scoreR > lbScore[i])) begin
          placed = 1'b1;
          if (n != 2'd3) begin
            nPid[n]   = pidR;
            nScore[n] = scoreR;
            nValid[n] = 1'b1;
            n         = n + 2'd1;
          end else begin
            n = n;
          end
        end else begin
          placed = placed;
        end
        if (n != 2'd3) begin
          nPid[n]   = lbPid[i];
          nScore[n] = lbScore[i];
          nValid[n] = 1'b1;
          n         = n + 2'd1;
        end else begin
          n = n;
        end
      end else begin
        n = n;
      end
    end
    if (!placed && (n != 2'd3)) begin
      nPid[n]   = pidR;
      nScore[n] = scoreR;
      nValid[n] = 1'b1;
    end else begin
      n = n;
    end
  end

  // Controller FSM with registered acks, RAM strobes and leaderboard.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pidR         <= '0;
      scoreR       <= '0;
      clrCnt       <= '0;
      memEnR       <= 1'b0;
      memWeR       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      clr_ack      <= 1'b0;
      upd_ack      <= 1'b0;
      upd_new_best <= 1'b0;
      rd_ack       <= 1'b0;
      rd_score     <= '0;
      lbPid        <= '{default: '0};
      lbScore      <= '{default: '0};
      lbValid      <= 3'b000;
    end else begin
      clr_ack      <= 1'b0;
      upd_ack      <= 1'b0;
      upd_new_best <= 1'b0;
      rd_ack       <= 1'b0;
      case (state)
        IDLE: begin
          if (!ackAny && clr_req) begin
            state     <= CLR;
            busy      <= 1'b1;
            lbValid   <= 3'b000;
            clrCnt    <= '0;
            memEnR    <= 1'b1;
            memWeR    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else if (!ackAny && upd_req) begin
            if (upd_guest) begin
              upd_ack <= 1'b1;
            end else begin
              state    <= UPD_RD;
              busy     <= 1'b1;
              pidR     <= upd_pid;
              scoreR   <= upd_score;
              memEnR   <= 1'b1;
              memWeR   <= 1'b0;
              mem_addr <= upd_pid;
            end
          end else if (!ackAny && rd_req) begin
            state    <= RD_RD;
            busy     <= 1'b1;
            memEnR   <= 1'b1;
            memWeR   <= 1'b0;
            mem_addr <= rd_pid;
          end else begin
            state <= IDLE;
          end
        end
        CLR: begin
          if (clrCnt == LAST_ADDR) begin
            state   <= IDLE;
            busy    <= 1'b0;
            memEnR  <= 1'b0;
            memWeR  <= 1'b0;
            clrCnt  <= '0;
            clr_ack <= 1'b1;
          end else begin
            clrCnt   <= clrCnt + ADDR_ONE;
            mem_addr <= clrCnt + ADDR_ONE;
          end
        end
        UPD_RD: begin
          state  <= UPD_CMP;
          memEnR <= 1'b0;
        end
        UPD_CMP: begin
          if (scoreR > mem_rdata) begin
            state     <= UPD_WR;
            memEnR    <= 1'b1;
            memWeR    <= 1'b1;
            mem_wdata <= scoreR;
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            upd_ack <= 1'b1;
          end
        end
        UPD_WR: begin
          state  <= TOP_INS;
          memEnR <= 1'b0;
          memWeR <= 1'b0;
        end
        TOP_INS: begin
          for (int j = 0; j < 3; j++) begin
            lbPid[j]   <= nPid[j];
            lbScore[j] <= nScore[j];
          end
          lbValid      <= nValid;
          state        <= IDLE;
          busy         <= 1'b0;
          upd_ack      <= 1'b1;
          upd_new_best <= 1'b1;
        end
        RD_RD: begin
          state  <= RD_CAP;
          memEnR <= 1'b0;
        end
        RD_CAP: begin
          rd_score <= mem_rdata;
          state    <= IDLE;
          busy     <= 1'b0;
          rd_ack   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          memEnR <= 1'b0;
          memWeR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_table_ctrl.sv
// Directed bench for score_table_ctrl with a behavioural single-port RAM and
// hand-computed expectations for latency, RAM contents and leaderboard order.
module tb_score_table_ctrl;

  localparam int SCORE_W = 7;
  localparam int PID_W   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clr_req = 1'b0;
  logic               clr_ack;
  logic               upd_req = 1'b0;
  logic [PID_W-1:0]   upd_pid = '0;
  logic               upd_guest = 1'b0;
  logic [SCORE_W-1:0] upd_score = '0;
  logic               upd_ack;
  logic               upd_new_best;
  logic               rd_req = 1'b0;
  logic [PID_W-1:0]   rd_pid = '0;
  logic               rd_ack;
  logic [SCORE_W-1:0] rd_score;
  logic [PID_W-1:0]   top_pid0, top_pid1, top_pid2;
  logic [SCORE_W-1:0] top_score0, top_score1, top_score2;
  logic [2:0]         top_valid;
  logic               busy;
  logic               mem_en, mem_we;
  logic [PID_W-1:0]   mem_addr;
  logic [SCORE_W-1:0] mem_wdata;
  logic [SCORE_W-1:0] mem_rdata = '0;

  logic [SCORE_W-1:0] ram [8];
  int writeCount = 0;
  int passCnt = 0;
  int totalCnt = 0;

  score_table_ctrl #(.SCORE_W(SCORE_W), .PID_W(PID_W)) dut (
    .clk(clk), .rst(rst),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .upd_req(upd_req), .upd_pid(upd_pid), .upd_guest(upd_guest), .upd_score(upd_score),
    .upd_ack(upd_ack), .upd_new_best(upd_new_best),
    .rd_req(rd_req), .rd_pid(rd_pid), .rd_ack(rd_ack), .rd_score(rd_score),
    .top_pid0(top_pid0), .top_pid1(top_pid1), .top_pid2(top_pid2),
    .top_score0(top_score0), .top_score1(top_score1), .top_score2(top_score2),
    .top_valid(top_valid), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
      writeCount    <= writeCount + 1;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = number of edges until the selected ack is seen, -1 on timeout.
  task automatic waitAck(input int sel, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if ((sel == 0 && clr_ack) || (sel == 1 && upd_ack) || (sel == 2 && rd_ack)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic doUpd(input logic [PID_W-1:0] pid, input logic guest,
                       input logic [SCORE_W-1:0] sc, output int lat, output logic nb);
    upd_pid = pid; upd_guest = guest; upd_score = sc; upd_req = 1'b1;
    waitAck(1, lat);
    nb = upd_new_best;
    upd_req = 1'b0;
    tick();
  endtask

  task automatic doRd(input logic [PID_W-1:0] pid, output int lat, output logic [SCORE_W-1:0] val);
    rd_pid = pid; rd_req = 1'b1;
    waitAck(2, lat);
    val = rd_score;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    totalCnt++;
    if ({clr_ack, upd_ack, upd_new_best, rd_ack, busy, mem_en, mem_we, rd_score} !== 14'd0) begin
      $display("FAIL reset_ctrl: got %b want 0", {clr_ack, upd_ack, upd_new_best, rd_ack, busy, mem_en, mem_we, rd_score});
    end else passCnt++;
    totalCnt++;
    if ({top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2, top_valid} !== 33'd0) begin
      $display("FAIL reset_top: got %h want 0", {top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2, top_valid});
    end else passCnt++;
    rd_pid = 3'd5; rd_req = 1'b1;
    tick();
    totalCnt++;
    if ({busy, mem_en, mem_we, mem_addr} !== {3'b110, 3'd5}) begin
      $display("FAIL read_issue: got %b want 110101", {busy, mem_en, mem_we, mem_addr});
    end else passCnt++;
    waitAck(2, lat);
    totalCnt++;
    if (lat !== 2) $display("FAIL read_latency: got %0d want 2 (after accept edge)", lat);
    else passCnt++;
    totalCnt++;
    if (rd_score !== 7'd0) $display("FAIL read_zero: got %0d want 0", rd_score);
    else passCnt++;
    rd_req = 1'b0;
    tick();
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy);
    else passCnt++;
  endtask

  task automatic test_update();
    int lat; logic nb; int wc;
    doUpd(3'd2, 1'b0, 7'd40, lat, nb);
    totalCnt++;
    if ({lat, nb} !== {32'd5, 1'b1}) $display("FAIL upd_best: got lat=%0d nb=%b want lat=5 nb=1", lat, nb);
    else passCnt++;
    totalCnt++;
    if (ram[2] !== 7'd40) $display("FAIL upd_ram: got %0d want 40", ram[2]);
    else passCnt++;
    totalCnt++;
    if ({top_pid0, top_score0, top_valid} !== {3'd2, 7'd40, 3'b001}) begin
      $display("FAIL upd_top: got pid=%0d score=%0d valid=%b want 2 40 001", top_pid0, top_score0, top_valid);
    end else passCnt++;
    wc = writeCount;
    doUpd(3'd2, 1'b0, 7'd30, lat, nb);
    totalCnt++;
    if ({lat, nb} !== {32'd3, 1'b0}) $display("FAIL upd_notbest: got lat=%0d nb=%b want lat=3 nb=0", lat, nb);
    else passCnt++;
    totalCnt++;
    if ({ram[2], writeCount - wc} !== {7'd40, 32'd0}) $display("FAIL upd_nowrite: got ram=%0d writes=%0d want 40 0", ram[2], writeCount - wc);
    else passCnt++;
    totalCnt++;
    if ({top_pid0, top_score0, top_valid} !== {3'd2, 7'd40, 3'b001}) begin
      $display("FAIL upd_top_keep: got pid=%0d score=%0d valid=%b want 2 40 001", top_pid0, top_score0, top_valid);
    end else passCnt++;
  endtask

  task automatic test_leaderboard();
    int lat; logic nb;
    doUpd(3'd1, 1'b0, 7'd50, lat, nb);
    doUpd(3'd3, 1'b0, 7'd50, lat, nb);
    doUpd(3'd4, 1'b0, 7'd60, lat, nb);
    doUpd(3'd5, 1'b0, 7'd10, lat, nb);
    totalCnt++;
    if ({lat, nb, ram[5]} !== {32'd5, 1'b1, 7'd10}) $display("FAIL lb_low_best: got lat=%0d nb=%b ram=%0d want 5 1 10", lat, nb, ram[5]);
    else passCnt++;
    totalCnt++;
    if ({top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2, top_valid} !==
        {3'd4, 7'd60, 3'd1, 7'd50, 3'd3, 7'd50, 3'b111}) begin
      $display("FAIL lb_order: got (%0d,%0d)(%0d,%0d)(%0d,%0d) %b want (4,60)(1,50)(3,50) 111",
               top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2, top_valid);
    end else passCnt++;
  endtask

  task automatic test_duplicate();
    int lat; logic nb;
    doUpd(3'd3, 1'b0, 7'd70, lat, nb);
    totalCnt++;
    if ({lat, nb} !== {32'd5, 1'b1}) $display("FAIL dup_best: got lat=%0d nb=%b want 5 1", lat, nb);
    else passCnt++;
    totalCnt++;
    if ({top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2, top_valid} !==
        {3'd3, 7'd70, 3'd4, 7'd60, 3'd1, 7'd50, 3'b111}) begin
      $display("FAIL dup_order: got (%0d,%0d)(%0d,%0d)(%0d,%0d) %b want (3,70)(4,60)(1,50) 111",
               top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2, top_valid);
    end else passCnt++;
  endtask

  task automatic test_back_to_back();
    int lat; int wc;
    wc = writeCount;
    upd_pid = 3'd6; upd_guest = 1'b1; upd_score = 7'd99; upd_req = 1'b1;
    rd_pid = 3'd4; rd_req = 1'b1;
    waitAck(1, lat);
    totalCnt++;
    if ({lat, upd_new_best, rd_ack} !== {32'd1, 1'b0, 1'b0}) begin
      $display("FAIL guest_ack: got lat=%0d nb=%b rd_ack=%b want 1 0 0", lat, upd_new_best, rd_ack);
    end else passCnt++;
    upd_req = 1'b0; upd_guest = 1'b0;
    // One ignored edge (ack cycle), accept edge, then two more to rd_ack.
    waitAck(2, lat);
    totalCnt++;
    if ({lat, rd_score} !== {32'd4, 7'd60}) $display("FAIL b2b_read: got lat=%0d score=%0d want 4 60", lat, rd_score);
    else passCnt++;
    rd_req = 1'b0;
    tick();
    totalCnt++;
    if ({ram[6], writeCount - wc} !== {7'd0, 32'd0}) $display("FAIL guest_nowrite: got ram=%0d writes=%0d want 0 0", ram[6], writeCount - wc);
    else passCnt++;
  endtask

  task automatic test_max_score();
    int lat; logic nb;
    doUpd(3'd7, 1'b0, 7'd127, lat, nb);
    totalCnt++;
    if ({lat, nb, ram[7]} !== {32'd5, 1'b1, 7'd127}) $display("FAIL max_best: got lat=%0d nb=%b ram=%0d want 5 1 127", lat, nb, ram[7]);
    else passCnt++;
    totalCnt++;
    if ({top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2} !==
        {3'd7, 7'd127, 3'd3, 7'd70, 3'd4, 7'd60}) begin
      $display("FAIL max_order: got (%0d,%0d)(%0d,%0d)(%0d,%0d) want (7,127)(3,70)(4,60)",
               top_pid0, top_score0, top_pid1, top_score1, top_pid2, top_score2);
    end else passCnt++;
    doUpd(3'd7, 1'b0, 7'd127, lat, nb);
    totalCnt++;
    if ({lat, nb} !== {32'd3, 1'b0}) $display("FAIL equal_notbest: got lat=%0d nb=%b want 3 0", lat, nb);
    else passCnt++;
  endtask

  task automatic test_clear_reset();
    int lat; int wc; logic anyNonZero; logic [SCORE_W-1:0] val;
    rd_pid = 3'd3; rd_req = 1'b1; clr_req = 1'b1;
    tick();
    totalCnt++;
    if ({busy, mem_en, mem_we, mem_addr, top_valid} !== {3'b111, 3'd0, 3'b000}) begin
      $display("FAIL clr_start: got %b want 111000000", {busy, mem_en, mem_we, mem_addr, top_valid});
    end else passCnt++;
    tick(); tick();
    rst = 1'b0; clr_req = 1'b0; rd_req = 1'b0;
    #1;
    totalCnt++;
    if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we);
    else passCnt++;
    tick();
    totalCnt++;
    if ({busy, clr_ack, rd_ack, top_valid, rd_score} !== 13'd0) begin
      $display("FAIL rst_midclr: got %b want 0", {busy, clr_ack, rd_ack, top_valid, rd_score});
    end else passCnt++;
    rst = 1'b1;
    tick(); tick();
    totalCnt++;
    if ({busy, clr_ack, upd_ack, rd_ack, mem_en} !== 5'd0) $display("FAIL rst_dropped: got %b want 0", {busy, clr_ack, upd_ack, rd_ack, mem_en});
    else passCnt++;
    wc = writeCount;
    clr_req = 1'b1;
    waitAck(0, lat);
    clr_req = 1'b0;
    totalCnt++;
    if ({lat, writeCount - wc} !== {32'd9, 32'd8}) $display("FAIL clr_latency: got lat=%0d writes=%0d want 9 8", lat, writeCount - wc);
    else passCnt++;
    tick();
    anyNonZero = 1'b0;
    for (int a = 0; a < 8; a++) anyNonZero = anyNonZero | (ram[a] != 7'd0);
    totalCnt++;
    if ({anyNonZero, top_valid, busy} !== 5'd0) $display("FAIL clr_result: got nz=%b valid=%b busy=%b want 0 000 0", anyNonZero, top_valid, busy);
    else passCnt++;
    doRd(3'd4, lat, val);
    totalCnt++;
    if ({lat, val} !== {32'd3, 7'd0}) $display("FAIL clr_read: got lat=%0d score=%0d want 3 0", lat, val);
    else passCnt++;
  endtask

  initial begin
    for (int a = 0; a < 8; a++) ram[a] = 7'd0;
    test_reset();
    test_update();
    test_leaderboard();
    test_duplicate();
    test_back_to_back();
    test_max_score();
    test_clear_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
